dm_cache_responder: RTL and testbench



---
 rtl/dm_cache_responder.sv | 216 +++++++++++++++++++++
 tb/tb_dm_cache_responder.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/dm_cache_responder.sv
// Direct-mapped, write-back, write-allocate cache controller answering Rd/Wr requests.
// Misses are serviced one word at a time over a req/ack backing-memory port.
module dm_cache_responder #(
    parameter int unsigned IDX_W = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Rd,
    input  logic        Wr,
    input  logic [15:0] Addr,
    input  logic [15:0] DataIn,
    output logic [15:0] DataOut,
    output logic        Done,
    output logic        Stall,
    output logic        CacheHit,
    output logic        Err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata
);

    localparam int unsigned LINES = 1 << IDX_W;
    localparam int unsigned TAG_W = 16 - IDX_W - 3;
    localparam int unsigned AW    = IDX_W + 2;
    localparam int unsigned DEPTH = LINES * 4;

    typedef enum logic [1:0] {IDLE, WB, FILL, FINISH} state_t;

    state_t state_q, state_d;

    logic [TAG_W-1:0] tag_q  [LINES];
    logic [15:0]      data_q [DEPTH];
    logic [LINES-1:0] valid_q, valid_d, dirty_q, dirty_d;

    logic             req_we_q;
    logic [TAG_W-1:0] req_tag_q;
    logic [IDX_W-1:0] req_idx_q;
    logic [1:0]       req_off_q;
    logic [15:0]      req_wdata_q;
    logic [1:0]       cnt_q, cnt_d, cnt_nx;

    logic [TAG_W-1:0] a_tag;
    logic [IDX_W-1:0] a_idx;
    logic [1:0]       a_off;
    logic             accept_c, hit_c;

    logic        done_d, hit_d, err_d, stall_d, mem_req_d, mem_we_d;
    logic [15:0] dout_d, mem_addr_d, mem_wdata_d;
    logic        data_we, tag_we;
    logic [AW-1:0] data_waddr;
    logic [15:0] data_wdata;

    assign a_tag    = Addr[15:IDX_W+3];
    assign a_idx    = Addr[IDX_W+2:3];
    assign a_off    = Addr[2:1];
    assign accept_c = (Rd ^ Wr) && !Addr[0];
    assign hit_c    = valid_q[a_idx] && (tag_q[a_idx] == a_tag);
    assign cnt_nx   = cnt_q + 2'd1;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        valid_d     = valid_q;
        dirty_d     = dirty_q;
        done_d      = 1'b0;
        hit_d       = 1'b0;
        err_d       = 1'b0;
        dout_d      = '0;
        mem_req_d   = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        data_we     = 1'b0;
        data_waddr  = {a_idx, a_off};
        data_wdata  = DataIn;
        tag_we      = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    if (hit_c) begin
                        done_d = 1'b1;
                        hit_d  = 1'b1;
                        if (Wr) begin
                            data_we        = 1'b1;
                            dirty_d[a_idx] = 1'b1;
                        end else begin
                            dout_d = data_q[{a_idx, a_off}];
                        end
                    end else if (valid_q[a_idx] && dirty_q[a_idx]) begin
                        state_d     = WB;
                        cnt_d       = 2'd0;
                        mem_req_d   = 1'b1;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = {tag_q[a_idx], a_idx, 3'b000};
                        mem_wdata_d = data_q[{a_idx, 2'b00}];
                    end else begin
                        state_d        = FILL;
                        cnt_d          = 2'd0;
                        valid_d[a_idx] = 1'b0;
                        mem_req_d      = 1'b1;
                        mem_addr_d     = {a_tag, a_idx, 3'b000};
                    end
                end else if (Rd || Wr) begin
                    err_d = 1'b1;
                end
            end
            WB: begin
                mem_req_d = 1'b1;
                mem_we_d  = 1'b1;
                if (mem_ack && mem_req) begin
                    if (cnt_q == 2'd3) begin
                        state_d            = FILL;
                        cnt_d              = 2'd0;
                        dirty_d[req_idx_q] = 1'b0;
                        valid_d[req_idx_q] = 1'b0;
                        mem_we_d           = 1'b0;
                        mem_addr_d         = {req_tag_q, req_idx_q, 3'b000};
                    end else begin
                        cnt_d       = cnt_nx;
                        mem_addr_d  = {tag_q[req_idx_q], req_idx_q, cnt_nx, 1'b0};
                        mem_wdata_d = data_q[{req_idx_q, cnt_nx}];
                    end
                end
            end
            FILL: begin
                mem_req_d = 1'b1;
                if (mem_ack && mem_req) begin
                    data_we    = 1'b1;
                    data_waddr = {req_idx_q, cnt_q};
                    data_wdata = mem_rdata;
                    if (cnt_q == 2'd3) begin
                        state_d            = FINISH;
                        mem_req_d          = 1'b0;
                        valid_d[req_idx_q] = 1'b1;
                        dirty_d[req_idx_q] = 1'b0;
                        tag_we             = 1'b1;
                    end else begin
                        cnt_d      = cnt_nx;
                        mem_addr_d = {req_tag_q, req_idx_q, cnt_nx, 1'b0};
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
                done_d  = 1'b1;
                if (req_we_q) begin
                    data_we            = 1'b1;
                    data_waddr         = {req_idx_q, req_off_q};
                    data_wdata         = req_wdata_q;
                    dirty_d[req_idx_q] = 1'b1;
                end else begin
                    dout_d = data_q[{req_idx_q, req_off_q}];
                end
            end
            default: state_d = IDLE;
        endcase

        stall_d = (state_d != IDLE);
    end

    // Control state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 2'd0;
            valid_q     <= '0;
            dirty_q     <= '0;
            req_we_q    <= 1'b0;
            req_tag_q   <= '0;
            req_idx_q   <= '0;
            req_off_q   <= 2'd0;
            req_wdata_q <= '0;
            Done        <= 1'b0;
            Stall       <= 1'b0;
            CacheHit    <= 1'b0;
            Err         <= 1'b0;
            DataOut     <= '0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            valid_q   <= valid_d;
            dirty_q   <= dirty_d;
            Done      <= done_d;
            Stall     <= stall_d;
            CacheHit  <= hit_d;
            Err       <= err_d;
            DataOut   <= dout_d;
            mem_req   <= mem_req_d;
            mem_we    <= mem_we_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            if (state_q == IDLE && accept_c) begin
                req_we_q    <= Wr;
                req_tag_q   <= a_tag;
                req_idx_q   <= a_idx;
                req_off_q   <= a_off;
                req_wdata_q <= DataIn;
            end
        end
    end

    // Tag and data storage carry no reset; valid bits qualify them
    always_ff @(posedge clk) begin
        if (data_we) data_q[data_waddr] <= data_wdata;
        if (tag_we)  tag_q[req_idx_q]   <= req_tag_q;
    end

endmodule

// File: tb/tb_dm_cache_responder.sv
// Directed, table-driven bench for dm_cache_responder with a zero-wait backing memory.
module tb_dm_cache_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        Rd, Wr;
    logic [15:0] Addr, DataIn, DataOut;
    logic        Done, Stall, CacheHit, Err;
    logic        mem_req, mem_we, mem_ack;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem [32768];
    int          wb_cnt = 0;
    int          fill_cnt = 0;
    logic [15:0] wb_addr_log[$];
    logic [15:0] wb_data_log[$];
    logic [15:0] fill_addr_log[$];

    always #5 clk = ~clk;

    dm_cache_responder #(.IDX_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .Rd(Rd), .Wr(Wr), .Addr(Addr), .DataIn(DataIn),
        .DataOut(DataOut), .Done(Done), .Stall(Stall), .CacheHit(CacheHit), .Err(Err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    assign mem_ack   = mem_req;
    assign mem_rdata = mem[mem_addr[15:1]];

    // Backing memory: word at byte address a starts as 0x1000+a, except 0x0010 = 0x1234
    initial begin
        for (int i = 0; i < 32768; i++) mem[i] = 16'(16'h1000 + 16'(i * 2));
        mem[8] = 16'h1234;
        forever begin
            @(posedge clk);
            if (mem_req && mem_ack) begin
                if (mem_we) begin
                    mem[mem_addr[15:1]] = mem_wdata;
                    wb_addr_log.push_back(mem_addr);
                    wb_data_log.push_back(mem_wdata);
                    wb_cnt++;
                end else begin
                    fill_addr_log.push_back(mem_addr);
                    fill_cnt++;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Called just after a rising edge; presents the request and waits for Done or Err
    task automatic run_req(input logic rd, input logic wr, input logic [15:0] addr,
                           input logic [15:0] din, output logic done, output logic err,
                           output logic hit, output logic [15:0] dout, output int lat,
                           output int stall_cnt);
        Rd = rd; Wr = wr; Addr = addr; DataIn = din;
        done = 1'b0; err = 1'b0; hit = 1'b0; dout = '0; lat = 0; stall_cnt = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            lat = c;
            if (CacheHit && !Done) begin
                checks++;
                errors++;
                $display("FAIL hit_without_done actual=1 required=0 at cycle %0d", c);
            end
            if (Done || Err) begin
                done = Done; err = Err; hit = CacheHit; dout = DataOut;
                break;
            end
            if (Stall) stall_cnt++;
        end
        if (!done && !err) begin
            checks++;
            errors++;
            $display("FAIL timeout addr=%h actual=no_response required=Done_or_Err", addr);
        end
        Rd = 1'b0; Wr = 1'b0;
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] din;
        logic        exp_err;
        logic        exp_hit;
        logic [15:0] exp_data;
        int          exp_lat;
        int          exp_wb;
        int          exp_fill;
    } vec_t;

    vec_t vecs [18];

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_Done"}, 32'(Done), 32'd0);
        chk({tag, "_Stall"}, 32'(Stall), 32'd0);
        chk({tag, "_CacheHit"}, 32'(CacheHit), 32'd0);
        chk({tag, "_Err"}, 32'(Err), 32'd0);
        chk({tag, "_mem_req"}, 32'(mem_req), 32'd0);
        chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        chk({tag, "_DataOut"}, 32'(DataOut), 32'd0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    endtask

    initial begin
        logic        d, e, h;
        logic [15:0] dout;
        int          lat, stl, wb0, f0, wl0, fl0;

        //           rd  wr  addr      din       err hit data      lat wb fill
        vecs[0]  = '{1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 16'h1234, 6, 0, 4};
        vecs[1]  = '{1'b1, 1'b0, 16'h0014, 16'h0000, 1'b0, 1'b1, 16'h1014, 1, 0, 0};
        vecs[2]  = '{1'b0, 1'b1, 16'h0012, 16'hBEEF, 1'b0, 1'b1, 16'h0000, 1, 0, 0};
        vecs[3]  = '{1'b1, 1'b0, 16'h0012, 16'h0000, 1'b0, 1'b1, 16'hBEEF, 1, 0, 0};
        vecs[4]  = '{1'b1, 1'b0, 16'h0050, 16'h0000, 1'b0, 1'b0, 16'h1050, 10, 4, 4};
        vecs[5]  = '{1'b1, 1'b1, 16'h0020, 16'h0000, 1'b1, 1'b0, 16'h0000, 1, 0, 0};
        vecs[6]  = '{1'b1, 1'b0, 16'h0021, 16'h0000, 1'b1, 1'b0, 16'h0000, 1, 0, 0};
        vecs[7]  = '{1'b0, 1'b1, 16'h0021, 16'h1111, 1'b1, 1'b0, 16'h0000, 1, 0, 0};
        vecs[8]  = '{1'b1, 1'b0, 16'h0016, 16'h0000, 1'b0, 1'b0, 16'h1016, 6, 0, 4};
        vecs[9]  = '{1'b0, 1'b1, 16'h0056, 16'h5A5A, 1'b0, 1'b0, 16'h0000, 6, 0, 4};
        vecs[10] = '{1'b1, 1'b0, 16'h0056, 16'h0000, 1'b0, 1'b1, 16'h5A5A, 1, 0, 0};
        vecs[11] = '{1'b1, 1'b0, 16'h0030, 16'h0000, 1'b0, 1'b0, 16'h1030, 6, 0, 4};
        vecs[12] = '{1'b0, 1'b1, 16'h0016, 16'h7777, 1'b0, 1'b0, 16'h0000, 10, 4, 4};
        vecs[13] = '{1'b1, 1'b0, 16'h0056, 16'h0000, 1'b0, 1'b0, 16'h5A5A, 10, 4, 4};
        vecs[14] = '{1'b1, 1'b0, 16'h0016, 16'h0000, 1'b0, 1'b0, 16'h7777, 6, 0, 4};
        vecs[15] = '{1'b1, 1'b0, 16'h00FE, 16'h0000, 1'b0, 1'b0, 16'h10FE, 6, 0, 4};
        vecs[16] = '{1'b1, 1'b0, 16'h00F8, 16'h0000, 1'b0, 1'b1, 16'h10F8, 1, 0, 0};
        vecs[17] = '{1'b1, 1'b0, 16'h0012, 16'h0000, 1'b0, 1'b1, 16'hBEEF, 1, 0, 0};

        rst_n = 1'b0; Rd = 1'b0; Wr = 1'b0; Addr = '0; DataIn = '0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Requests run back-to-back: the next one is presented inside the Done cycle
        for (int i = 0; i < 18; i++) begin
            wb0 = wb_cnt; f0 = fill_cnt;
            wl0 = wb_addr_log.size(); fl0 = fill_addr_log.size();
            run_req(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].din, d, e, h, dout, lat, stl);
            chk($sformatf("v%0d_done", i), 32'(d), 32'(!vecs[i].exp_err));
            chk($sformatf("v%0d_err", i), 32'(e), 32'(vecs[i].exp_err));
            chk($sformatf("v%0d_hit", i), 32'(h), 32'(vecs[i].exp_hit));
            if (!vecs[i].exp_err)
                chk($sformatf("v%0d_data", i), 32'(dout), 32'(vecs[i].exp_data));
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            chk($sformatf("v%0d_stall_cycles", i), 32'(stl), 32'(vecs[i].exp_lat - 1));
            chk($sformatf("v%0d_wb_words", i), 32'(wb_cnt - wb0), 32'(vecs[i].exp_wb));
            chk($sformatf("v%0d_fill_words", i), 32'(fill_cnt - f0), 32'(vecs[i].exp_fill));
            if (vecs[i].exp_fill == 4) begin
                for (int k = 0; k < 4; k++)
                    chk($sformatf("v%0d_fill_addr%0d", i, k), 32'(fill_addr_log[fl0 + k]),
                        32'((vecs[i].addr & 16'hFFF8) + 16'(2 * k)));
            end
            if (i == 4) begin
                for (int k = 0; k < 4; k++)
                    chk($sformatf("v4_wb_addr%0d", k), 32'(wb_addr_log[wl0 + k]),
                        32'(16'h0010 + 16'(2 * k)));
                chk("v4_wb_data_beef", 32'(wb_data_log[wl0 + 1]), 32'h0000BEEF);
                chk("v4_wb_data0", 32'(wb_data_log[wl0]), 32'h00001234);
            end
            if (i == 12)
                chk("v12_wb_data_5a5a", 32'(wb_data_log[wl0 + 3]), 32'h00005A5A);
        end

        // Reset in the middle of a refill
        wb0 = wb_cnt; f0 = fill_cnt;
        Rd = 1'b1; Wr = 1'b0; Addr = 16'h0080; DataIn = '0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (fill_cnt - f0 >= 2) break;
        end
        chk("midfill_acks_before_reset", 32'(fill_cnt - f0), 32'd2);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("midfill_reset");
        Rd = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        f0 = fill_cnt;
        run_req(1'b1, 1'b0, 16'h0080, 16'h0000, d, e, h, dout, lat, stl);
        chk("refill_done", 32'(d), 32'd1);
        chk("refill_hit", 32'(h), 32'd0);
        chk("refill_data", 32'(dout), 32'h00001080);
        chk("refill_words", 32'(fill_cnt - f0), 32'd4);
        chk("refill_latency", 32'(lat), 32'd6);
        chk("refill_no_wb", 32'(wb_cnt - wb0), 32'd0);

        // Resident line now hits with no memory traffic
        f0 = fill_cnt;
        run_req(1'b1, 1'b0, 16'h0086, 16'h0000, d, e, h, dout, lat, stl);
        chk("post_refill_hit", 32'(h), 32'd1);
        chk("post_refill_data", 32'(dout), 32'h00001086);
        chk("post_refill_no_fill", 32'(fill_cnt - f0), 32'd0);

        @(posedge clk);
        #1;
        chk("idle_done_low", 32'(Done), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
